// File: rtl/aim_isa_pkg.sv
// AIM instruction-set constants shared by the encoder and decoder:
// class nibbles, request-class encoding and instruction field positions.
package aim_isa_pkg;

  localparam logic [3:0] CLS_AI   = 4'h1;
  localparam logic [3:0] CLS_GFX  = 4'h2;
  localparam logic [3:0] CLS_CUST = 4'hF;

  typedef enum logic [1:0] {
    RC_AI   = 2'b00,
    RC_GFX  = 2'b01,
    RC_CUST = 2'b10,
    RC_RSVD = 2'b11
  } req_class_e;

  localparam int CLS_MSB  = 31;
  localparam int CLS_LSB  = 28;
  localparam int TYPE_MSB = 27;
  localparam int TYPE_LSB = 24;
  localparam int DST_MSB  = 23;
  localparam int DST_LSB  = 16;
  localparam int SRC_MSB  = 15;
  localparam int SRC_LSB  = 8;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;
  localparam int RAW_MSB  = 27;
  localparam int RAW_LSB  = 0;
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;

endpackage

// File: rtl/aim_instruction_encoder_if.sv
// Request and instruction-stream channels of the AIM instruction encoder.
interface aim_instruction_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_class;
  logic [3:0]  req_type;
  logic [7:0]  req_dst;
  logic [7:0]  req_src;
  logic [7:0]  req_imm;
  logic [27:0] req_raw;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;

  modport master (
    output req_valid, req_class, req_type, req_dst, req_src, req_imm, req_raw, out_ready,
    input  req_ready, out_valid, out_instr
  );

  modport slave (
    input  req_valid, req_class, req_type, req_dst, req_src, req_imm, req_raw, out_ready,
    output req_ready, out_valid, out_instr
  );
endinterface

// File: rtl/aim_instruction_encoder_fifo.sv
// First-word-fall-through synchronous FIFO; the read port holds the last
// popped word while empty so the output never shows stale storage.
module aim_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] last_q;
  logic             push_ok, pop_ok;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o = wr_q - rd_q;
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = empty_o ? last_q : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      last_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (pop_ok) last_q <= mem_q[rd_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/aim_instruction_encoder.sv
// Packs decoded-form requests into 32-bit AIM words, buffers them in a FWFT
// FIFO and streams them out; reserved-class requests are counted and flagged.
module aim_instruction_encoder
  import aim_isa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  aim_instruction_encoder_if.slave bus,
  output logic                   err_pulse,
  output logic [CNT_W-1:0]       issued_count,
  output logic [CNT_W-1:0]       rejected_count,
  output logic [$clog2(DEPTH):0] fifo_level
);
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  req_class_e       cls;
  logic             full, empty;
  logic             accept, reject, push, pop;
  logic [31:0]      word;
  logic             err_q, err_d;
  logic [CNT_W-1:0] iss_q, iss_d, rej_q, rej_d;

  assign cls           = req_class_e'(bus.req_class);
  assign bus.req_ready = !full;
  assign accept        = bus.req_valid && !full;
  assign reject        = accept && (cls == RC_RSVD);
  assign push          = accept && !reject;
  assign bus.out_valid = !empty;
  assign pop           = !empty && bus.out_ready;

  always_comb begin
    word = '0;
    case (cls)
      RC_AI, RC_GFX: begin
        word[CLS_MSB:CLS_LSB]   = (cls == RC_AI) ? CLS_AI : CLS_GFX;
        word[TYPE_MSB:TYPE_LSB] = bus.req_type;
        word[DST_MSB:DST_LSB]   = bus.req_dst;
        word[SRC_MSB:SRC_LSB]   = bus.req_src;
        word[IMM_MSB:IMM_LSB]   = bus.req_imm;
      end
      RC_CUST: begin
        word[CLS_MSB:CLS_LSB] = CLS_CUST;
        word[RAW_MSB:RAW_LSB] = bus.req_raw;
      end
      default: word = '0;
    endcase
  end

  always_comb begin
    err_d = reject;
    iss_d = pop    ? sat_inc(iss_q) : iss_q;
    rej_d = reject ? sat_inc(rej_q) : rej_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      iss_q <= '0;
      rej_q <= '0;
    end else begin
      err_q <= err_d;
      iss_q <= iss_d;
      rej_q <= rej_d;
    end
  end

  assign err_pulse      = err_q;
  assign issued_count   = iss_q;
  assign rejected_count = rej_q;

  aim_sync_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush_i(flush),
    .push_i (push),
    .wdata_i(word),
    .pop_i  (pop),
    .rdata_o(bus.out_instr),
    .level_o(fifo_level),
    .full_o (full),
    .empty_o(empty)
  );
endmodule
